// File: rtl/freq_gate_ctrl_if.sv
// Control/status bundle between the frequency-counter chain and its
// measurement sequencer.
interface freq_gate_ctrl_if;
    logic       run;
    logic       auto_range;
    logic [1:0] range_sel;
    logic       cnt_ovf;
    logic       cnt_msd_zero;
    logic       cnt_clr;
    logic       gate;
    logic       latch;
    logic [1:0] range;
    logic [5:0] dp_n;
    logic       ovf_flag;
    logic       busy;

    modport master (
        output run, auto_range, range_sel, cnt_ovf, cnt_msd_zero,
        input  cnt_clr, gate, latch, range, dp_n, ovf_flag, busy
    );

    modport slave (
        input  run, auto_range, range_sel, cnt_ovf, cnt_msd_zero,
        output cnt_clr, gate, latch, range, dp_n, ovf_flag, busy
    );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer: clear, gate window, settle, auto-range decision,
// display latch and hold, with kHz decimal-point steering.
module freq_gate_ctrl #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned MAX_RETRY     = 2
) (
    input logic             clk,
    input logic             rst,
    freq_gate_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_EVAL,
        S_LATCH,
        S_HOLD
    } state_t;

    localparam logic [31:0] GT0_M1  = 32'(CLK_FREQ - 1);
    localparam logic [31:0] GT1_M1  = 32'(CLK_FREQ / 10 - 1);
    localparam logic [31:0] GT2_M1  = 32'(CLK_FREQ / 100 - 1);
    localparam logic [31:0] SET_M1  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] HOLD_M1 = 32'(HOLD_CYCLES - 1);
    localparam logic [7:0]  RMAX    = 8'(MAX_RETRY);
    localparam logic [5:0]  DP_R0   = 6'b110111;
    localparam logic [5:0]  DP_R1   = 6'b111011;
    localparam logic [5:0]  DP_R2   = 6'b111101;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [7:0]  r_retry;
    logic [1:0]  r_range;
    logic [5:0]  r_dp_n;
    logic        r_auto;
    logic        r_cnt_clr;
    logic        r_gate;
    logic        r_latch;
    logic        r_ovf_flag;
    logic        r_busy;

    logic [1:0]  w_sel;
    logic [1:0]  w_next_range;
    logic [31:0] w_gate_load;
    logic [5:0]  w_dp_n;

    // Range chosen at CLEAR, its gate length, and the kHz decimal point.
    always_comb begin
        w_sel        = (bus.range_sel == 2'd3) ? 2'd2 : bus.range_sel;
        w_next_range = bus.auto_range ? r_range : w_sel;
        case (w_next_range)
            2'd0:    w_gate_load = GT0_M1;
            2'd1:    w_gate_load = GT1_M1;
            default: w_gate_load = GT2_M1;
        endcase
        case (r_range)
            2'd0:    w_dp_n = DP_R0;
            2'd1:    w_dp_n = DP_R1;
            default: w_dp_n = DP_R2;
        endcase
    end

    // Sequencer FSM with registered strobes, range and retry tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_range    <= 2'd0;
            r_dp_n     <= DP_R0;
            r_auto     <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_gate     <= 1'b0;
            r_latch    <= 1'b0;
            r_ovf_flag <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cnt_clr <= 1'b0;
            r_latch   <= 1'b0;
            r_dp_n    <= w_dp_n;
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state   <= S_CLEAR;
                        r_cnt_clr <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_auto  <= bus.auto_range;
                    r_range <= w_next_range;
                    r_cnt   <= w_gate_load;
                    r_gate  <= 1'b1;
                    r_state <= S_GATE;
                end
                S_GATE: begin
                    if (r_cnt == 32'd0) begin
                        r_gate  <= 1'b0;
                        r_cnt   <= SET_M1;
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 32'd0) begin
                        r_state <= S_EVAL;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_EVAL: begin
                    if (!r_auto) begin
                        r_ovf_flag <= bus.cnt_ovf;
                        r_latch    <= 1'b1;
                        r_state    <= S_LATCH;
                    end else if (r_retry == RMAX) begin
                        r_ovf_flag <= bus.cnt_ovf;
                        r_retry    <= '0;
                        r_latch    <= 1'b1;
                        r_state    <= S_LATCH;
                    end else if (bus.cnt_ovf && r_range != 2'd2) begin
                        r_range   <= r_range + 2'd1;
                        r_retry   <= r_retry + 8'd1;
                        r_cnt_clr <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else if (bus.cnt_ovf) begin
                        r_ovf_flag <= 1'b1;
                        r_latch    <= 1'b1;
                        r_state    <= S_LATCH;
                    end else if (bus.cnt_msd_zero && r_range != 2'd0) begin
                        r_range   <= r_range - 2'd1;
                        r_retry   <= r_retry + 8'd1;
                        r_cnt_clr <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else begin
                        r_ovf_flag <= 1'b0;
                        r_retry    <= '0;
                        r_latch    <= 1'b1;
                        r_state    <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_cnt   <= HOLD_M1;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_cnt != 32'd0) begin
                        r_cnt <= r_cnt - 32'd1;
                    end else if (bus.run) begin
                        r_cnt_clr <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_clr  = r_cnt_clr;
    assign bus.gate     = r_gate;
    assign bus.latch    = r_latch;
    assign bus.range    = r_range;
    assign bus.dp_n     = r_dp_n;
    assign bus.ovf_flag = r_ovf_flag;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl driven by a behavioural counter chain
// fed with random input frequencies.
module tb_freq_gate_ctrl;

    localparam int CLKF   = 1000;
    localparam int SETTLE = 8;
    localparam int HOLD   = 50;
    localparam int MAXR   = 2;

    typedef struct {
        bit         is_latch;
        int         len;
        logic [1:0] rng;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst;
    freq_gate_ctrl_if bus();

    freq_gate_ctrl #(
        .CLK_FREQ(CLKF),
        .SETTLE_CYCLES(SETTLE),
        .HOLD_CYCLES(HOLD),
        .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    int     n_latch = 0;
    int     cyc = 0;
    int     last_gate = 0;
    int     glen = 0;
    bit     skip_gate = 0;
    bit     prev_gate = 0;
    bit     prev_clr = 0;
    longint f_in = 0;
    longint gcount = 0;
    int     mr = 0;
    int     mt = 0;
    exp_t   sb[$];

    function automatic longint p10(input int r);
        longint v = 1;
        for (int i = 0; i < r; i++) v = v * 10;
        return v;
    endfunction

    function automatic logic [5:0] dp_of(input logic [1:0] r);
        case (r)
            2'd0:    return 6'b110111;
            2'd1:    return 6'b111011;
            default: return 6'b111101;
        endcase
    endfunction

    task automatic push_gate(input int r);
        exp_t e;
        e.is_latch = 0;
        e.len = int'(longint'(CLKF) / p10(r));
        e.rng = 2'(r);
        e.ovf = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_latch(input int r, input bit ov);
        exp_t e;
        e.is_latch = 1;
        e.len = 0;
        e.rng = 2'(r);
        e.ovf = ov;
        sb.push_back(e);
    endtask

    // Reference: one full measurement (including any re-ranging) per call.
    task automatic push_meas(input bit au, input int sel, input longint f);
        longint c;
        bit     ov;
        bit     z;
        bit     done;
        done = 0;
        if (!au) begin
            mr = (sel > 2) ? 2 : sel;
            push_gate(mr);
            c = f / p10(mr);
            push_latch(mr, c >= 1_000_000);
        end else begin
            while (!done) begin
                push_gate(mr);
                c = f / p10(mr);
                ov = (c >= 1_000_000);
                z = (c < 10_000);
                if (mt == MAXR) begin
                    push_latch(mr, ov);
                    mt = 0;
                    done = 1;
                end else if (ov && mr < 2) begin
                    mr++;
                    mt++;
                end else if (ov) begin
                    push_latch(mr, 1);
                    done = 1;
                end else if (z && mr > 0) begin
                    mr--;
                    mt++;
                end else begin
                    push_latch(mr, 0);
                    mt = 0;
                    done = 1;
                end
            end
        end
    endtask

    // Behavioural six-digit counter chain: counts f_in per second of gate.
    always @(negedge clk) begin
        longint c;
        if (bus.cnt_clr) gcount = 0;
        else if (bus.gate) gcount++;
        c = gcount * f_in / CLKF;
        bus.cnt_ovf = (c >= 1_000_000);
        bus.cnt_msd_zero = (c < 10_000);
    end

    // Monitor: pulse shapes, latencies and scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.cnt_clr) begin
            checks++;
            if (bus.gate || bus.latch || prev_clr) begin
                failures++;
                $display("FAIL clr_pulse: gate=%0b latch=%0b prev_clr=%0b want 0 0 0",
                         bus.gate, bus.latch, prev_clr);
            end
        end
        if (bus.gate && !prev_gate) begin
            checks++;
            glen = 0;
            if (!prev_clr) begin
                failures++;
                $display("FAIL gate_start: prev cnt_clr=%0b want 1", prev_clr);
            end
        end
        if (bus.gate) glen++;
        if (!bus.gate && prev_gate) begin
            last_gate = cyc - 1;
            if (skip_gate) begin
                skip_gate = 0;
            end else begin
                checks++;
                if (sb.size() == 0 || sb[0].is_latch) begin
                    failures++;
                    $display("FAIL gate_unexpected: len=%0d no gate expected", glen);
                end else begin
                    e = sb.pop_front();
                    if (glen != e.len) begin
                        failures++;
                        $display("FAIL gate_len: got %0d want %0d", glen, e.len);
                    end
                end
            end
        end
        if (bus.latch) begin
            n_latch++;
            checks++;
            if (cyc - last_gate != SETTLE + 2 || bus.gate) begin
                failures++;
                $display("FAIL latch_latency: got %0d want %0d gate=%0b",
                         cyc - last_gate, SETTLE + 2, bus.gate);
            end
            checks++;
            if (sb.size() == 0 || !sb[0].is_latch) begin
                failures++;
                $display("FAIL latch_unexpected: range=%0d", bus.range);
            end else begin
                e = sb.pop_front();
                if (bus.range !== e.rng || bus.ovf_flag !== e.ovf ||
                    bus.dp_n !== dp_of(e.rng)) begin
                    failures++;
                    $display("FAIL latch_result: range=%0d ovf=%0b dp=%b want %0d %0b %b",
                             bus.range, bus.ovf_flag, bus.dp_n,
                             e.rng, e.ovf, dp_of(e.rng));
                end
            end
        end
        prev_gate = bus.gate;
        prev_clr = bus.cnt_clr;
    end

    task automatic timeout(input string what);
        failures++;
        $display("FAIL timeout_%s: event not seen within bound", what);
    endtask

    task automatic do_meas(input bit au, input int sel, input longint f,
                           input int nmeas, input bit drop_in_gate);
        int t;
        int target;
        bit bad;
        for (int k = 0; k < nmeas; k++) push_meas(au, sel, f);
        bus.auto_range = au;
        bus.range_sel = 2'(sel);
        f_in = f;
        bus.run = 1'b1;
        target = n_latch + nmeas - 1;
        t = 0;
        while (n_latch < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (n_latch < target) timeout("latch");
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.cnt_clr && t < 2000);
        checks++;
        if (!bus.cnt_clr) timeout("clr");
        if (drop_in_gate) repeat (3) @(negedge clk);
        bus.run = 1'b0;
        t = 0;
        while (bus.busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.busy) timeout("idle");
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.cnt_clr || bus.busy || bus.gate) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL idle_quiet: activity after run dropped, want none");
        end
    endtask

    function automatic longint rand_freq();
        case ($urandom_range(0, 3))
            0:       return longint'($urandom_range(1, 9_999));
            1:       return longint'($urandom_range(10_000, 999_999));
            2:       return longint'($urandom_range(1_000_000, 99_999_999));
            default: return longint'($urandom_range(100_000_000, 900_000_000));
        endcase
    endfunction

    initial begin
        int t;
        bit bad;
        rst = 1'b1;
        bus.run = 1'b0;
        bus.auto_range = 1'b0;
        bus.range_sel = 2'd0;
        bus.cnt_ovf = 1'b0;
        bus.cnt_msd_zero = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cnt_clr || bus.gate || bus.latch || bus.busy || bus.ovf_flag ||
            bus.range !== 2'd0 || bus.dp_n !== 6'b110111) begin
            failures++;
            $display("FAIL reset_state: clr=%0b gate=%0b latch=%0b busy=%0b ovf=%0b range=%0d dp=%b",
                     bus.cnt_clr, bus.gate, bus.latch, bus.busy, bus.ovf_flag,
                     bus.range, bus.dp_n);
        end
        rst = 1'b0;
        @(negedge clk);

        do_meas(0, 1, 50_000, 1, 0);
        do_meas(0, 0, 5_000, 1, 0);
        do_meas(1, 0, 2_000_000, 1, 0);
        do_meas(0, 0, 5_000, 1, 0);
        do_meas(1, 0, 500_000_000, 1, 0);
        do_meas(0, 3, 100, 1, 0);
        do_meas(1, 0, 100, 1, 0);
        do_meas(1, 0, 300_000, 2, 0);
        do_meas(1, 0, 40_000_000, 1, 1);

        do_meas(0, 2, 900_000_000, 1, 0);
        bus.auto_range = 1'b0;
        bus.range_sel = 2'd2;
        bus.run = 1'b1;
        t = 0;
        while (!bus.gate && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!bus.gate) timeout("gate");
        repeat (4) @(negedge clk);
        bus.run = 1'b0;
        skip_gate = 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mr = 0;
        mt = 0;
        checks++;
        if (bus.gate || bus.busy || bus.range !== 2'd0 ||
            bus.dp_n !== 6'b110111 || bus.ovf_flag) begin
            failures++;
            $display("FAIL mid_gate_reset: gate=%0b busy=%0b range=%0d dp=%b ovf=%0b",
                     bus.gate, bus.busy, bus.range, bus.dp_n, bus.ovf_flag);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.latch || bus.cnt_clr || bus.gate) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_quiet: strobe seen after reset with run=0");
        end

        for (int i = 0; i < 12; i++) begin
            do_meas(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    rand_freq(), int'($urandom_range(1, 2)),
                    1'($urandom_range(0, 1)));
        end

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d expected events left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Measurement sequencer for the six-digit BCD frequency counter chain.
- Generates the counter clear pulse, the gate (count-enable) window of range-dependent length, and the display latch strobe.
- Auto-ranges between three gate lengths using the chain's overflow and leading-zero status.
- Drives the active-low decimal-point select so the display always reads in kHz.

Parameters:
CLK_FREQ, 50_000_000, system clock cycles per second; must be divisible by 100
SETTLE_CYCLES, 8, idle cycles after gate closes before evaluating chain status (ripple settle)
HOLD_CYCLES, 25_000_000, cycles the latched result is held before the next measurement
MAX_RETRY, 2, max consecutive range changes before forcing a latch

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
run  input  1  level; high = continuous measurement cycles
auto_range  input  1  1 = automatic ranging, 0 = manual range from range_sel
range_sel  input  2  manual range; values 3 treated as 2
cnt_ovf  input  1  sticky carry-out of top digit, cleared by cnt_clr
cnt_msd_zero  input  1  top two digits of chain are zero (count < 10_000)
cnt_clr  output  1  one-cycle clear pulse to counter chain
gate  output  1  counter enable window
latch  output  1  one-cycle strobe to capture chain into display registers
range  output  2  active range: 0 = 1 s gate, 1 = 100 ms, 2 = 10 ms
dp_n  output  6  decimal point select, active-low, one-hot, bit 0 = rightmost digit
ovf_flag  output  1  last latched result overflowed
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst=1 at clk edge, any state): state IDLE; cnt_clr, gate, latch, ovf_flag, busy = 0; range = 0; dp_n = 6'b110111; retry counter = 0.
- Gate length GT(r) = CLK_FREQ / 10^r cycles; gate is high for exactly GT(range) consecutive cycles.
- dp_n from range: 0 -> 6'b110111, 1 -> 6'b111011, 2 -> 6'b111101. Updates the cycle after range changes.
- States:
  - IDLE: outputs low. run=1 -> CLEAR.
  - CLEAR (1 cycle): cnt_clr=1. If auto_range=0, range <= min(range_sel,2). -> GATE.
  - GATE (GT cycles): gate=1; range_sel and auto_range changes ignored. -> SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): gate=0. -> EVAL.
  - EVAL (1 cycle), rules in priority order:
    - Manual mode: -> LATCH, ovf_flag <= cnt_ovf.
    - Auto mode, retry = MAX_RETRY: -> LATCH, ovf_flag <= cnt_ovf, retry <= 0.
    - cnt_ovf and range<2: range+1, retry+1, -> CLEAR (no latch).
    - cnt_ovf and range=2: ovf_flag <= 1, -> LATCH.
    - cnt_msd_zero and range>0: range-1, retry+1, -> CLEAR.
    - Otherwise: ovf_flag <= 0, retry <= 0, -> LATCH.
  - LATCH (1 cycle): latch=1. -> HOLD.
  - HOLD (HOLD_CYCLES cycles): at end, run=1 -> CLEAR, else -> IDLE.
- Down-range cannot oscillate: count < 10_000 at range r gives < 100_000 at r-1.
- run deasserted mid-cycle: current measurement completes through HOLD, then IDLE; no truncated gate.
- rst mid-GATE: gate drops on the next edge; no latch pulse is emitted.
- cnt_clr, gate and latch are mutually exclusive and registered, with no combinational path from inputs.
- Latency from run rising (IDLE) to cnt_clr: 1 cycle. cnt_clr to first gate cycle: 1 cycle. Last gate cycle to latch: SETTLE_CYCLES+2 cycles.

Test Plan:
1. CLK_FREQ=1000, SETTLE=8, HOLD=50, auto=0, range_sel=1; assert run. Required: cnt_clr 1 cycle, then gate high exactly 100 cycles, latch 10 cycles after gate falls, dp_n=6'b111011, ovf_flag=0.
2. Auto mode at range 0, cnt_ovf=1 in EVAL. Required: no latch; range -> 1; new CLEAR plus 100-cycle gate. With cnt_ovf=0 and msd_zero=0 in the next EVAL: latch, range=1.
3. Auto mode, cnt_ovf held 1 always. Required: range 0 -> 1 -> 2, then latch with ovf_flag=1 and gate length 10.
4. Auto mode at range 2, cnt_msd_zero held 1. Required: range 2 -> 1 -> 0, then forced latch (retry = MAX_RETRY), and retry counter cleared.
5. rst pulsed for 1 cycle mid-GATE. Required: next cycle gate=0, busy=0, range=0, dp_n=6'b110111, and no latch for at least 5 cycles while run=0.
6. run dropped during GATE. Required: latch still issued, HOLD completes, then IDLE with busy=0 and no further cnt_clr.
